// File: rtl/mac16_15_4.sv
// mac16_15_4: streaming unsigned multiply-accumulate stage that sits behind
// the 16x16 Dadda multiplier built from 15:4 counters.
// Three pipeline stages:
//   S1 registers operand pairs from the input stream.
//   S2 registers the multiplier product.
//   S3 accumulates products into groups closed by in_last and presents each
//      group sum on a valid/ready result port.
// A stalled result port (out_valid && !out_ready) freezes the whole pipeline.
// Optional build macro MAC_SATURATE_EN: the group sum clamps at 2^ACC_W-1
// instead of wrapping. Without it the sum wraps and out_ovf is a sticky flag.

// Combinational 16x16 unsigned multiplier (15:4-counter Dadda tree).
module dadda16x16_15_4 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = 32'(a) * 32'(b);
endmodule

module mac16_15_4 #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [15:0]      out_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Reduce the (ACC_W+1)-bit running sum to ACC_W bits: clamp or wrap.
    function automatic logic [ACC_W-1:0] sat_fold(input logic [ACC_W:0] sum);
`ifdef MAC_SATURATE_EN
        if (sum[ACC_W])
            return '1;
        else
            return sum[ACC_W-1:0];
`else
        return sum[ACC_W-1:0];
`endif
    endfunction

    logic             en;
    logic [15:0]      a_p0;
    logic [15:0]      b_p0;
    logic             last_p0;
    logic             vld_p0;
    logic [31:0]      prod;
    logic [31:0]      prod_p1;
    logic             last_p1;
    logic             vld_p1;
    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [15:0]      cnt;
    logic [15:0]      cnt_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] new_acc;
    logic [15:0]      new_cnt;
    logic             new_ovf;
    logic             res_load;

    // Only a held, unconsumed result blocks the pipeline.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1 control: beat-valid and group-close flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else if (en) begin
            vld_p0  <= in_valid;
            last_p0 <= in_last;
        end
    end

    // S1 data: operands are only meaningful alongside vld_p0, so no reset.
    always_ff @(posedge clk) begin
        if (in_valid && en) begin
            a_p0 <= in_a;
            b_p0 <= in_b;
        end
    end

    dadda16x16_15_4 u_mul (
        .a (a_p0),
        .b (b_p0),
        .p (prod)
    );

    // S2 control: carry valid and last alongside the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (en) begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    // S2 data: registered product.
    always_ff @(posedge clk) begin
        if (en)
            prod_p1 <= prod;
    end

    // S3 next-state: fold the product into the open group or close it.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        res_load  = 1'b0;
        sum       = {1'b0, acc} + (ACC_W+1)'(prod_p1);
        new_acc   = sat_fold(sum);
        new_cnt   = cnt + 16'd1;
        new_ovf   = ovf | sum[ACC_W];
        if (en && vld_p1) begin
            if (last_p1) begin
                res_load  = 1'b1;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                ovf_nxt   = 1'b0;
                state_nxt = IDLE;
            end else begin
                acc_nxt   = new_acc;
                cnt_nxt   = new_cnt;
                ovf_nxt   = new_ovf;
                state_nxt = ACCUM;
            end
        end
    end

    // S3 state: accumulator FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Result port: load a closed group, or retire the held one on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (res_load) begin
            out_valid <= 1'b1;
            out_acc   <= new_acc;
            out_cnt   <= new_cnt;
            out_ovf   <= new_ovf;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
